// File: rtl/ast_word_packer.sv
// rtl/ast_word_packer.sv - packs narrow Avalon-ST words into wide beats with timeout/flush
module ast_word_packer #(
    parameter int AST_SYMBOLS = 1,
    parameter int BYTE_W      = 8,
    parameter int PACK_CNT    = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [AST_SYMBOLS*BYTE_W-1:0]                ast_sink_data_i,
    input  logic                                         ast_sink_valid_i,
    output logic                                         ast_sink_ready_o,
    input  logic                                         flush_i,
    output logic [PACK_CNT*AST_SYMBOLS*BYTE_W-1:0]       ast_source_data_o,
    output logic [$clog2(PACK_CNT+1)-1:0]                ast_source_cnt_o,
    output logic                                         ast_source_valid_o,
    input  logic                                         ast_source_ready_i
);
    localparam int IN_W   = AST_SYMBOLS * BYTE_W;
    localparam int OUT_W  = PACK_CNT * IN_W;
    localparam int CNT_W  = $clog2(PACK_CNT + 1);
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  FULL     = CNT_W'(PACK_CNT);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic [IN_W-1:0]   slot_q [PACK_CNT];
    logic [IN_W-1:0]   slot_d [PACK_CNT];
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              flush_pend_q, flush_pend_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_valid_d;

    logic              out_free;
    logic              accept;
    logic              timeout_hit;
    logic              xfer_req;
    logic              xfer;
    logic [OUT_W-1:0]  packed_beat;

    // Handshake decode; ready is held low while reset is asserted.
    assign out_free         = !out_valid_q || ast_source_ready_i;
    assign ast_sink_ready_o = rst_n_i && ((fill_q < FULL) || out_free);
    assign accept           = ast_sink_valid_i && ast_sink_ready_o;
    assign timeout_hit      = (TIMEOUT != 0) && (idle_q == IDLE_MAX);
    assign xfer_req         = (fill_q != '0) &&
                              ((fill_q == FULL) || timeout_hit || flush_pend_q);
    assign xfer             = xfer_req && out_free;

    assign ast_source_data_o  = out_data_q;
    assign ast_source_cnt_o   = out_cnt_q;
    assign ast_source_valid_o = out_valid_q;

    // Gather filled slots into a beat, zeroing slots beyond the fill count.
    always_comb begin
        packed_beat = '0;
        for (int i = 0; i < PACK_CNT; i++) begin
            if (CNT_W'(i) < fill_q) begin
                packed_beat[i*IN_W +: IN_W] = slot_q[i];
            end
        end
    end

    // Next-state for accumulator, idle timer, flush request and output register.
    always_comb begin
        for (int i = 0; i < PACK_CNT; i++) begin
            slot_d[i] = slot_q[i];
        end
        fill_d       = fill_q;
        idle_d       = idle_q;
        flush_pend_d = flush_pend_q;
        out_data_d   = out_data_q;
        out_cnt_d    = out_cnt_q;
        out_valid_d  = out_valid_q;

        if (xfer) begin
            out_data_d  = packed_beat;
            out_cnt_d   = fill_q;
            out_valid_d = 1'b1;
            if (accept) begin
                slot_d[0] = ast_sink_data_i;
                fill_d    = CNT_W'(1);
            end else begin
                fill_d = '0;
            end
        end else begin
            if (out_valid_q && ast_source_ready_i) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                for (int i = 0; i < PACK_CNT; i++) begin
                    if (fill_q == CNT_W'(i)) begin
                        slot_d[i] = ast_sink_data_i;
                    end
                end
                fill_d = fill_q + 1'b1;
            end
        end

        // Idle timer restarts on any activity and only runs while words wait.
        if (accept || xfer || (fill_q == '0)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end

        // A new flush always wins so words accepted alongside a transfer still get out.
        if (flush_i) begin
            flush_pend_d = 1'b1;
        end else if (xfer || (fill_q == '0)) begin
            flush_pend_d = 1'b0;
        end
    end

    // State registers with asynchronous clear; pending words are dropped on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < PACK_CNT; i++) begin
                slot_q[i] <= '0;
            end
            fill_q       <= '0;
            idle_q       <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < PACK_CNT; i++) begin
                slot_q[i] <= slot_d[i];
            end
            fill_q       <= fill_d;
            idle_q       <= idle_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_cnt_q    <= out_cnt_d;
            out_valid_q  <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_ast_word_packer.sv
// tb/tb_ast_word_packer.sv - self-checking bench for ast_word_packer
module tb_ast_word_packer;
    localparam int P  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sd = '0;
    logic        sv = 1'b0;
    logic        snk_rdy;
    logic        flush = 1'b0;
    logic [31:0] src_data;
    logic [2:0]  src_cnt;
    logic        src_valid;
    logic        src_rdy = 1'b0;

    ast_word_packer #(
        .AST_SYMBOLS(1), .BYTE_W(8), .PACK_CNT(P), .TIMEOUT(TO)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .ast_sink_data_i    (sd),
        .ast_sink_valid_i   (sv),
        .ast_sink_ready_o   (snk_rdy),
        .flush_i            (flush),
        .ast_source_data_o  (src_data),
        .ast_source_cnt_o   (src_cnt),
        .ast_source_valid_o (src_valid),
        .ast_source_ready_i (src_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit last_acc = 1'b0;

    logic [31:0] got_d[$];
    int          got_c[$];

    // Reference model: pending words as a queue, output beat as plain values.
    logic [7:0]  m_acc[$];
    int          m_idle;
    bit          m_fp;
    bit          m_v;
    logic [31:0] m_d;
    int          m_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc.delete();
        m_idle = 0;
        m_fp   = 1'b0;
        m_v    = 1'b0;
        m_d    = '0;
        m_c    = 0;
    endtask

    // One clock: compare at the falling edge, predict the next rising edge, return 1ns after it.
    task automatic tick();
        int          fill;
        bit          m_free, m_rdy, acc, xf;
        logic [31:0] beat;
        @(negedge clk);
        last_acc = 1'b0;
        if (!rst_n) begin
            model_reset();
            chk("rst_valid", src_valid, 1'b0);
            chk("rst_ready", snk_rdy, 1'b0);
            chk("rst_data", src_data, 32'h0);
            chk("rst_cnt", src_cnt, 32'h0);
        end else begin
            fill   = m_acc.size();
            m_free = !m_v || src_rdy;
            m_rdy  = (fill < P) || m_free;
            chk("valid", src_valid, m_v);
            if (m_v) begin
                chk("data", src_data, m_d);
                chk("cnt", src_cnt, m_c);
            end
            chk("sink_ready", snk_rdy, m_rdy);
            if (src_valid && src_rdy) begin
                got_d.push_back(src_data);
                got_c.push_back(int'(src_cnt));
            end
            last_acc = sv && snk_rdy;
            acc = sv && m_rdy;
            xf  = (fill > 0) && ((fill == P) || (TO != 0 && m_idle == TO) || m_fp) && m_free;
            if (xf) begin
                beat = '0;
                for (int i = 0; i < fill; i++) beat = beat | (32'(m_acc[i]) << (8 * i));
                m_d = beat;
                m_c = fill;
                m_v = 1'b1;
                m_acc.delete();
            end else if (m_v && src_rdy) begin
                m_v = 1'b0;
            end
            if (acc) m_acc.push_back(sd);
            if (flush) m_fp = 1'b1;
            else if (xf || fill == 0) m_fp = 1'b0;
            if (acc || xf || fill == 0) m_idle = 0;
            else if (m_idle < TO) m_idle = m_idle + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] w);
        int n;
        sv = 1'b1;
        sd = w;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 60);
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
        sv = 1'b0;
    endtask

    initial begin
        int c0, n, nv, idx;
        model_reset();
        tick();
        tick();
        chk("reset_valid", src_valid, 1'b0);
        chk("reset_cnt", src_cnt, 32'h0);
        rst_n = 1'b1;
        src_rdy = 1'b1;
        tick();

        // 1: one full beat, valid one cycle after the last accept, for one cycle
        got_d.delete(); got_c.delete();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("t1_not_yet", src_valid, 1'b0);
        tick();
        chk("t1_valid", src_valid, 1'b1);
        chk("t1_data", src_data, 32'h44332211);
        chk("t1_cnt", src_cnt, 32'd4);
        tick();
        chk("t1_one_cycle", src_valid, 1'b0);

        // 2: continuous stream without bubbles
        got_d.delete(); got_c.delete();
        c0 = cyc;
        for (int i = 1; i <= 8; i++) send(8'(i));
        chk("t2_cycles", cyc - c0, 32'd8);
        repeat (3) tick();
        chk("t2_beats", got_d.size(), 32'd2);
        if (got_d.size() == 2) begin
            chk("t2_beat0", got_d[0], 32'h04030201);
            chk("t2_beat1", got_d[1], 32'h08070605);
            chk("t2_cnt0", got_c[0], 32'd4);
            chk("t2_cnt1", got_c[1], 32'd4);
        end

        // 3: idle timeout emits a partial beat
        send(8'hA1); send(8'hA2);
        n = 0;
        do begin
            tick();
            n++;
        end while (!src_valid && n < 40);
        chk("t3_edges", n, 32'd17);
        chk("t3_data", src_data, 32'h0000A2A1);
        chk("t3_cnt", src_cnt, 32'd2);
        tick();

        // 4: backpressure then drain
        src_rdy = 1'b0;
        got_d.delete(); got_c.delete();
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            sv = 1'b1;
            sd = 8'(8'h41 + idx);
            tick();
            if (last_acc) idx++;
        end
        chk("t4_accepted", idx, 32'd8);
        chk("t4_ready_low", snk_rdy, 1'b0);
        chk("t4_hold_valid", src_valid, 1'b1);
        chk("t4_hold_data", src_data, 32'h44434241);
        src_rdy = 1'b1;
        n = 0;
        while (idx < 12 && n < 40) begin
            sd = 8'(8'h41 + idx);
            tick();
            n++;
            if (last_acc) idx++;
        end
        sv = 1'b0;
        repeat (4) tick();
        chk("t4_beats", got_d.size(), 32'd3);
        if (got_d.size() == 3) begin
            chk("t4_beat0", got_d[0], 32'h44434241);
            chk("t4_beat1", got_d[1], 32'h48474645);
            chk("t4_beat2", got_d[2], 32'h4C4B4A49);
            chk("t4_cnt2", got_c[2], 32'd4);
        end

        // 5: explicit flush, then a flush with nothing buffered
        send(8'h55); send(8'h66); send(8'h77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_not_yet", src_valid, 1'b0);
        tick();
        chk("t5_valid", src_valid, 1'b1);
        chk("t5_data", src_data, 32'h00776655);
        chk("t5_cnt", src_cnt, 32'd3);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (src_valid) nv++;
        end
        chk("t5_empty_flush", nv, 32'd0);

        // 6: asynchronous reset discards a held beat and pending words
        src_rdy = 1'b0;
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        send(8'hB1); send(8'hB2);
        chk("t6_pre_valid", src_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", src_valid, 1'b0);
        chk("t6_async_ready", snk_rdy, 1'b0);
        chk("t6_async_data", src_data, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        src_rdy = 1'b1;
        got_d.delete(); got_c.delete();
        send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
        repeat (4) tick();
        chk("t6_beats", got_d.size(), 32'd1);
        if (got_d.size() == 1) begin
            chk("t6_data", got_d[0], 32'hD4D3D2D1);
            chk("t6_cnt", got_c[0], 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
